// File: rtl/conv_kernel_seq_ctrl.sv
// Sequencer and accumulator for the 2-output-channel 3x3 int8 conv kernel.
// Issues window/weight beats into a fixed-latency kernel, tracks each beat
// with a {valid, first, last} tag through a KERNEL_LAT delay line, sums the
// kernel outputs over num_ich input channels and presents one accumulated
// pixel pair per group on a backpressured output port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holds valid and its payload stable until the
// transfer. in_ready may depend combinationally on out_valid/out_ready;
// out_valid never depends on out_ready within the same cycle.
module conv_kernel_seq_ctrl #(
  parameter int KERNEL_LAT = 5,
  parameter int ACC_W      = 24,
  parameter int ICH_W      = 10,
  parameter int PIX_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [ICH_W-1:0]        cfg_num_ich,
  input  logic [PIX_W-1:0]        cfg_num_pix,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      kern_ofm_ch1,
  input  logic signed [17:0]      kern_ofm_ch2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc_ch1,
  output logic signed [ACC_W-1:0] out_acc_ch2,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ICH_W-1:0] ICH_ONE = ICH_W'(1);
  localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

  state_t                  state;
  logic [ICH_W-1:0]        num_ich;
  logic [ICH_W-1:0]        ich_cnt;
  logic [PIX_W-1:0]        num_pix;
  logic [PIX_W-1:0]        pix_cnt;

  // Delay-line tags; bit 0 is the newest stage, bit KERNEL_LAT-1 lines up
  // with the kernel output currently on kern_ofm_ch1/ch2.
  logic [KERNEL_LAT-1:0]   tag_v;
  logic [KERNEL_LAT-1:0]   tag_f;
  logic [KERNEL_LAT-1:0]   tag_l;

  logic signed [ACC_W-1:0] acc1;
  logic signed [ACC_W-1:0] acc2;

  logic                    beat_last;
  logic                    last_in_flight;
  logic                    out_drain;
  logic                    issue;
  logic                    line_busy;
  logic                    smp_v;
  logic                    smp_f;
  logic                    smp_l;
  logic signed [ACC_W-1:0] ext1;
  logic signed [ACC_W-1:0] ext2;
  logic signed [ACC_W-1:0] sum1;
  logic signed [ACC_W-1:0] sum2;

  assign dbg_state = state;

  // Issue gating and next accumulator value. Only a group-closing beat can
  // be held back: at most one finished group may be outstanding, either
  // still in the kernel or parked in the output register.
  always_comb begin
    beat_last      = (ich_cnt == num_ich - ICH_ONE);
    last_in_flight = |(tag_v & tag_l);
    out_drain      = out_valid & out_ready;
    in_ready       = (state == S_RUN) &&
                     (!beat_last || (!last_in_flight && (!out_valid || out_drain)));
    issue          = in_valid & in_ready;
    line_busy      = |tag_v;
    smp_v          = tag_v[KERNEL_LAT-1];
    smp_f          = tag_f[KERNEL_LAT-1];
    smp_l          = tag_l[KERNEL_LAT-1];
    ext1           = {{(ACC_W-18){kern_ofm_ch1[17]}}, kern_ofm_ch1};
    ext2           = {{(ACC_W-18){kern_ofm_ch2[17]}}, kern_ofm_ch2};
    sum1           = smp_f ? ext1 : acc1 + ext1;
    sum2           = smp_f ? ext2 : acc2 + ext2;
  end

  // Job FSM: configuration latch, channel/pixel counters, busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      num_ich <= '0;
      num_pix <= '0;
      ich_cnt <= '0;
      pix_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            num_ich <= (cfg_num_ich == '0) ? ICH_ONE : cfg_num_ich;
            num_pix <= cfg_num_pix;
            ich_cnt <= '0;
            pix_cnt <= '0;
            busy    <= 1'b1;
            state   <= (cfg_num_pix == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (beat_last) begin
              ich_cnt <= '0;
              pix_cnt <= pix_cnt + PIX_ONE;
              if (pix_cnt == num_pix - PIX_ONE) begin
                state <= S_DRAIN;
              end
            end else begin
              ich_cnt <= ich_cnt + ICH_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (!line_busy && !out_valid) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag delay line, per-group accumulation and the held output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v       <= '0;
      tag_f       <= '0;
      tag_l       <= '0;
      acc1        <= '0;
      acc2        <= '0;
      out_acc_ch1 <= '0;
      out_acc_ch2 <= '0;
      out_valid   <= 1'b0;
    end else begin
      tag_v <= {tag_v[KERNEL_LAT-2:0], issue};
      tag_f <= {tag_f[KERNEL_LAT-2:0], issue && (ich_cnt == '0)};
      tag_l <= {tag_l[KERNEL_LAT-2:0], issue && beat_last};
      if (smp_v) begin
        acc1 <= sum1;
        acc2 <= sum2;
      end
      // The gating above guarantees the register is empty or emptying
      // whenever a closing sample arrives, so capture never overwrites.
      if (smp_v && smp_l) begin
        out_acc_ch1 <= sum1;
        out_acc_ch2 <= sum2;
        out_valid   <= 1'b1;
      end else if (out_drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_kernel_seq_ctrl.sv
// Bench for conv_kernel_seq_ctrl: a kernel model returns queued per-beat
// values KERNEL_LAT cycles after each issue, a negedge monitor scores every
// delivered pixel pair against an expected queue, and a job table plus a few
// hand-written sequences cover latency, throughput, backpressure, wrap,
// mid-job reset and edge configurations.
module tb_conv_kernel_seq_ctrl;

  localparam int LAT   = 5;
  localparam int ACC_W = 24;
  localparam int ICH_W = 10;
  localparam int PIX_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_start = 1'b0;
  logic [ICH_W-1:0]        cfg_num_ich = '0;
  logic [PIX_W-1:0]        cfg_num_pix = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [17:0]      kern_ofm_ch1;
  logic signed [17:0]      kern_ofm_ch2;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [ACC_W-1:0] out_acc_ch1;
  logic signed [ACC_W-1:0] out_acc_ch2;
  logic                    busy;
  logic                    done;
  logic [1:0]              dbg_state;

  conv_kernel_seq_ctrl #(
    .KERNEL_LAT(LAT), .ACC_W(ACC_W), .ICH_W(ICH_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_num_ich(cfg_num_ich), .cfg_num_pix(cfg_num_pix),
    .in_valid(in_valid), .in_ready(in_ready),
    .kern_ofm_ch1(kern_ofm_ch1), .kern_ofm_ch2(kern_ofm_ch2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc_ch1(out_acc_ch1), .out_acc_ch2(out_acc_ch2),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- shared bench state ----------------
  logic signed [17:0]      b1_q[$];
  logic signed [17:0]      b2_q[$];
  logic signed [ACC_W-1:0] exp1_q[$];
  logic signed [ACC_W-1:0] exp2_q[$];
  logic signed [17:0]      k1_pipe[LAT];
  logic signed [17:0]      k2_pipe[LAT];
  bit                      feed_en = 1'b0;
  int                      stall_cnt = 0;
  int                      n_issued = 0;
  int                      first_issue_cyc = 0;
  int                      last_issue_cyc = 0;
  int                      rise_cyc = 0;
  int                      done_cnt = 0;
  int                      drain_cyc_q[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Kernel model: each issued beat's values appear LAT cycles later; idle
  // stages carry junk so untagged samples would corrupt sums if used.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = LAT - 1; i > 0; i--) begin
      k1_pipe[i] <= k1_pipe[i-1];
      k2_pipe[i] <= k2_pipe[i-1];
    end
    if (in_valid && in_ready && b1_q.size() > 0) begin
      k1_pipe[0] <= b1_q.pop_front();
      k2_pipe[0] <= b2_q.pop_front();
      if (n_issued == 0) first_issue_cyc = cyc;
      last_issue_cyc = cyc;
      n_issued++;
    end else begin
      k1_pipe[0] <= 18'sh15555;
      k2_pipe[0] <= 18'sh0aaaa;
    end
  end
  assign kern_ofm_ch1 = k1_pipe[LAT-1];
  assign kern_ofm_ch2 = k2_pipe[LAT-1];

  // Upstream source: present a beat whenever one is queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      in_valid = feed_en && (b1_q.size() > 0);
    end
  end

  // Downstream sink: out_ready low while stall_cnt counts down.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic                    prev_valid = 1'b0;
  logic                    prev_ready = 1'b0;
  logic                    prev_drain = 1'b0;
  logic signed [ACC_W-1:0] prev1 = '0;
  logic signed [ACC_W-1:0] prev2 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_drain = 1'b0;
    end else begin
      // A drained result is never replaced by a new one in the same cycle.
      if (prev_drain) check("no_result_on_drain", 32'(out_valid), 0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_ch1", 32'(out_acc_ch1), 32'(prev1));
        check("hold_ch2", 32'(out_acc_ch2), 32'(prev2));
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        drain_cyc_q.push_back(cyc);
        if (exp1_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: ch1=%0d ch2=%0d, expected no output",
                   out_acc_ch1, out_acc_ch2);
        end else begin
          check("out_ch1", 32'(out_acc_ch1), 32'(exp1_q.pop_front()));
          check("out_ch2", 32'(out_acc_ch2), 32'(exp2_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_drain = out_valid && out_ready;
      prev1      = out_acc_ch1;
      prev2      = out_acc_ch2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int ich, input int pix);
    cfg_num_ich = ICH_W'(ich);
    cfg_num_pix = PIX_W'(pix);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, limit);
    end
  endtask

  task automatic push_beat(input int v1, input int v2);
    b1_q.push_back(18'(v1));
    b2_q.push_back(18'(v2));
  endtask

  task automatic push_exp(input int e1, input int e2);
    exp1_q.push_back(24'(e1));
    exp2_q.push_back(24'(e2));
  endtask

  typedef struct {
    int ich;
    int pix;
    int c1;
    int c2;
    int e1;
    int e2;
    bit restart;
  } job_t;

  job_t jobs[6];

  task automatic run_table_job(input job_t j);
    int eff;
    eff = (j.ich == 0) ? 1 : j.ich;
    for (int p = 0; p < j.pix; p++) begin
      for (int i = 0; i < eff; i++) push_beat(j.c1, j.c2);
      push_exp(j.e1, j.e2);
    end
    n_issued = 0;
    feed_en  = 1'b1;
    start_job(j.ich, j.pix);
    if (j.restart) begin
      repeat (3) tick();
      cfg_num_pix = PIX_W'(7);
      cfg_start   = 1'b1;
      tick();
      cfg_start   = 1'b0;
    end
    wait_done(2000, "table_job");
    feed_en = 1'b0;
    repeat (3) tick();
    check("table_issued", n_issued, eff * j.pix);
    check("table_pending", exp1_q.size(), 0);
    check("table_busy_after", 32'(busy), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic signed [ACC_W-1:0] s1;
    logic signed [ACC_W-1:0] s2;
    logic signed [17:0]      v1;
    logic signed [17:0]      v2;

    jobs[0] = '{2,   2,   10,      -3,     20,      -6,     1'b0};
    jobs[1] = '{0,   2,   77,      -77,    77,      -77,    1'b0};
    jobs[2] = '{5,   1,   -131072, 131071, -655360, 655355, 1'b0};
    jobs[3] = '{6,   3,   1000,    -1,     6000,    -6,     1'b1};
    jobs[4] = '{1,   4,   -1,      5,      -1,      5,      1'b0};
    jobs[5] = '{130, 1,   131071,  131071, 262014,  262014, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_acc_ch1", 32'(out_acc_ch1), 0);
    check("rst_acc_ch2", 32'(out_acc_ch2), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single pixel, three channels, latency from last issue
    push_beat(100, -131072);
    push_beat(-50, 1);
    push_beat(7, 1);
    push_exp(57, -131070);
    n_issued = 0;
    feed_en  = 1'b1;
    start_job(3, 1);
    check("single_busy", 32'(busy), 1);
    wait_done(100, "single");
    feed_en = 1'b0;
    check("single_latency", rise_cyc - last_issue_cyc, LAT + 1);
    check("single_issued", n_issued, 3);
    check("single_busy_after", 32'(busy), 0);
    repeat (2) tick();

    // Back-to-back: 8 channels x 4 pixels at full rate
    for (int p = 0; p < 4; p++) begin
      s1 = '0;
      s2 = '0;
      for (int i = 0; i < 8; i++) begin
        v1 = 18'(1000 * p - 37 * i);
        v2 = 18'(-2000 * p + 5 * i * i);
        b1_q.push_back(v1);
        b2_q.push_back(v2);
        s1 = s1 + 24'(v1);
        s2 = s2 + 24'(v2);
      end
      exp1_q.push_back(s1);
      exp2_q.push_back(s2);
    end
    n_issued = 0;
    drain_cyc_q.delete();
    feed_en = 1'b1;
    start_job(8, 4);
    wait_done(200, "b2b");
    feed_en = 1'b0;
    check("b2b_issued", n_issued, 32);
    check("b2b_issue_span", last_issue_cyc - first_issue_cyc, 31);
    check("b2b_out_count", drain_cyc_q.size(), 4);
    if (drain_cyc_q.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        check("b2b_out_spacing", drain_cyc_q[k] - drain_cyc_q[k-1], 8);
      end
    end
    repeat (2) tick();

    // Backpressure with one channel per pixel
    push_beat(11, -4);
    push_beat(-22, 5);
    push_beat(33, -6);
    push_exp(11, -4);
    push_exp(-22, 5);
    push_exp(33, -6);
    stall_cnt = 20;
    n_issued  = 0;
    feed_en   = 1'b1;
    start_job(1, 3);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check("bp_first_valid", 32'(out_valid), 1);
    repeat (3) tick();
    check("bp_refuse_last", 32'(in_ready), 0);
    check("bp_issued_held", n_issued, 1);
    check("bp_out_ch1_held", 32'(out_acc_ch1), 11);
    wait_done(200, "bp");
    feed_en = 1'b0;
    check("bp_issued", n_issued, 3);
    check("bp_pending", exp1_q.size(), 0);
    repeat (2) tick();

    // Job table
    for (int j = 0; j < 6; j++) run_table_job(jobs[j]);

    // Reset mid-job with a held result and beats in flight
    for (int i = 0; i < 12; i++) push_beat(9, -9);
    push_exp(36, -36);
    stall_cnt = 40;
    n_issued  = 0;
    feed_en   = 1'b1;
    start_job(4, 3);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("mid_held_ch1", 32'(out_acc_ch1), 36);
    check("mid_held_ch2", 32'(out_acc_ch2), -36);
    check("mid_issued", n_issued, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_ch1", 32'(out_acc_ch1), 0);
    check("mid_rst_ch2", 32'(out_acc_ch2), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    feed_en   = 1'b0;
    stall_cnt = 0;
    b1_q.delete();
    b2_q.delete();
    exp1_q.delete();
    exp2_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    push_beat(5, -7);
    push_beat(6, 8);
    push_exp(11, 1);
    n_issued = 0;
    feed_en  = 1'b1;
    start_job(2, 1);
    wait_done(100, "post_rst");
    feed_en = 1'b0;
    check("post_rst_issued", n_issued, 2);
    check("post_rst_pending", exp1_q.size(), 0);
    repeat (2) tick();

    // Zero-pixel job: done two cycles after the start pulse
    cfg_num_ich = ICH_W'(3);
    cfg_num_pix = '0;
    cfg_start   = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("zero_pix_in_ready", 32'(in_ready), 0);
    check("zero_pix_busy", 32'(busy), 1);
    check("zero_pix_done_early", 32'(done), 0);
    tick();
    check("zero_pix_done", 32'(done), 1);
    check("zero_pix_busy_low", 32'(busy), 0);
    tick();
    check("zero_pix_done_once", 32'(done), 0);
    check("zero_pix_in_ready_after", 32'(in_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
